// File: rtl/prio_event_monitor_pkg.sv
// rtl/prio_event_monitor_pkg.sv - shared types and width helpers for prio_event_monitor
package prio_event_monitor_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int idx_width(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int entry_width(input int num_ch, input int ts_w);
    return idx_width(num_ch) + ts_w;
  endfunction

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_TS_W   = 32;
  localparam int DEF_IDX_W  = idx_width(DEF_NUM_CH);

  // Log entry layout for the default configuration; the FIFO stores {idx, ts} flat.
  typedef struct packed {
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_TS_W-1:0]  ts;
  } log_entry_t;

endpackage

// File: rtl/prio_event_monitor_log_fifo.sv
// rtl/prio_event_monitor_log_fifo.sv - event_log_fifo: sync FIFO with valid/ready pop and drop flag
module event_log_fifo
  import prio_event_monitor_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         drop,
  output logic         ovf,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign valid = (count != '0);
  assign pop   = valid & ready & ~clr;
  // A pop in the same cycle frees the slot, so a full log still accepts the push.
  assign wr_en = push & ~clr & (~full | pop);
  assign drop  = push & ~clr & full & ~pop;
  // Head reads zero while empty so reset/clear show clean outputs without resetting storage.
  assign head  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/prio_event_monitor.sv
// rtl/prio_event_monitor.sv - event arbiter (fixed/round-robin) with hit counters, timestamp and log
module prio_event_monitor
  import prio_event_monitor_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  CNT_W     = 16,
  parameter int  TS_W      = 32,
  parameter int  LOG_DEPTH = 8,
  localparam int IDX_W     = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rr_mode,
  input  logic [NUM_CH-1:0] ev_i,
  output logic              win_valid,
  output logic [IDX_W-1:0]  win_idx,
  input  logic [IDX_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0]  cnt_data,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [IDX_W-1:0]  log_idx,
  output logic [TS_W-1:0]   log_ts,
  output logic              log_ovf,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int ENT_W = entry_width(NUM_CH, TS_W);

  arb_mode_e        mode;
  logic [TS_W-1:0]  ts_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic             any_ev;
  logic [IDX_W-1:0] fix_idx;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] win_nxt;
  logic [IDX_W:0]   ptr_inc;
  logic             push;
  logic             drop;
  logic [ENT_W-1:0] head;

  assign mode   = arb_mode_e'(rr_mode);
  assign any_ev = |ev_i;

  always_comb begin
    fix_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ev_i[i]) fix_idx = IDX_W'(i);
    end
  end

  // Scan from rr_ptr upward, wrapping at NUM_CH, and take the first asserted line.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CH)) cand = cand - (IDX_W+1)'(NUM_CH);
      if (!rr_found && ev_i[cand[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_nxt = (mode == ARB_RR) ? rr_idx : fix_idx;
    ptr_inc = {1'b0, win_nxt} + (IDX_W+1)'(1);
    if (ptr_inc == (IDX_W+1)'(NUM_CH)) ptr_inc = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q      <= '0;
      rr_ptr_q  <= '0;
      win_valid <= 1'b0;
      win_idx   <= '0;
    end else if (clr) begin
      ts_q      <= '0;
      rr_ptr_q  <= '0;
      win_valid <= 1'b0;
      win_idx   <= '0;
    end else begin
      ts_q      <= ts_q + TS_W'(1);
      win_valid <= any_ev;
      if (any_ev) begin
        win_idx <= win_nxt;
        // Fixed mode leaves the pointer alone so round-robin resumes where it stopped.
        if (mode == ARB_RR) rr_ptr_q <= ptr_inc[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ev_i[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_data = '0;
    if ({1'b0, cnt_sel} < (IDX_W+1)'(NUM_CH)) cnt_data = cnt_q[cnt_sel];
  end

  // Logged timestamp is the value held before the sampling edge.
  assign push = any_ev & ~clr;

  event_log_fifo #(
    .W     (ENT_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (push),
    .push_data ({win_nxt, ts_q}),
    .drop      (drop),
    .ovf       (log_ovf),
    .valid     (log_valid),
    .ready     (log_ready),
    .head      (head)
  );

  assign log_idx = head[ENT_W-1 -: IDX_W];
  assign log_ts  = head[TS_W-1:0];

endmodule

// File: tb/tb_prio_event_monitor.sv
// tb/tb_prio_event_monitor.sv - scoreboard bench for prio_event_monitor (NUM_CH=4, CNT_W=4, LOG_DEPTH=8)
module tb_prio_event_monitor;
  import prio_event_monitor_pkg::*;

  typedef struct packed {
    logic       v;
    logic [1:0] idx;
  } win_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        rr_mode = 1'b0;
  logic [3:0]  ev_i = 4'b0;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  cnt_sel = 2'd0;
  logic [3:0]  cnt_data;
  logic        log_valid;
  logic        log_ready = 1'b0;
  logic [1:0]  log_idx;
  logic [31:0] log_ts;
  logic        log_ovf;
  logic [3:0]  drop_cnt;

  int n_err = 0;
  int n_checks = 0;

  win_t        exp_win[$];
  log_entry_t  exp_log[$];
  logic [31:0] ts_m;
  logic        hold_prev = 1'b0;
  logic [33:0] hold_data = '0;
  win_t        mw;
  log_entry_t  me;

  prio_event_monitor #(
    .NUM_CH    (4),
    .CNT_W     (4),
    .TS_W      (32),
    .LOG_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .rr_mode   (rr_mode),
    .ev_i      (ev_i),
    .win_valid (win_valid),
    .win_idx   (win_idx),
    .cnt_sel   (cnt_sel),
    .cnt_data  (cnt_data),
    .log_valid (log_valid),
    .log_ready (log_ready),
    .log_idx   (log_idx),
    .log_ts    (log_ts),
    .log_ovf   (log_ovf),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: timestamps expected in log entries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ts_m <= '0;
    else if (clr) ts_m <= '0;
    else          ts_m <= ts_m + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] ev, input logic rr, input logic v,
                      input logic [1:0] idx, input logic logged);
    win_t       w;
    log_entry_t e;
    ev_i    = ev;
    rr_mode = rr;
    e.idx   = idx;
    e.ts    = ts_m;
    @(posedge clk);
    w.v   = v;
    w.idx = idx;
    exp_win.push_back(w);
    if (v && logged) exp_log.push_back(e);
    #1;
    ev_i = 4'b0;
  endtask

  task automatic do_clr(input logic [3:0] ev);
    win_t w;
    clr  = 1'b1;
    ev_i = ev;
    @(posedge clk);
    w.v   = 1'b0;
    w.idx = 2'd0;
    exp_win.push_back(w);
    exp_log.delete();
    #1;
    clr  = 1'b0;
    ev_i = 4'b0;
  endtask

  task automatic cnt_chk(input logic [1:0] sel, input logic [3:0] exp);
    cnt_sel = sel;
    #1;
    chk($sformatf("cnt[%0d]", sel), 64'(cnt_data), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_win.size() > 0) begin
      mw = exp_win.pop_front();
      chk("win_valid", 64'(win_valid), 64'(mw.v));
      if (mw.v) chk("win_idx", 64'(win_idx), 64'(mw.idx));
    end
    if (rst_n && log_valid && log_ready) begin
      if (exp_log.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL log_pop: got entry idx=%0d ts=%0d expected none", log_idx, log_ts);
      end else begin
        me = exp_log.pop_front();
        chk("log_idx", 64'(log_idx), 64'(me.idx));
        chk("log_ts", 64'(log_ts), 64'(me.ts));
      end
    end
    if (hold_prev && rst_n) begin
      chk("log_hold_valid", 64'(log_valid), 64'(1));
      chk("log_hold_data", 64'({log_idx, log_ts}), 64'(hold_data));
    end
    hold_prev = rst_n && !clr && log_valid && !log_ready;
    hold_data = {log_idx, log_ts};
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_win_valid", 64'(win_valid), 64'(0));
    chk("rst_win_idx", 64'(win_idx), 64'(0));
    chk("rst_log_valid", 64'(log_valid), 64'(0));
    chk("rst_log_idx", 64'(log_idx), 64'(0));
    chk("rst_log_ts", 64'(log_ts), 64'(0));
    chk("rst_log_ovf", 64'(log_ovf), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    cnt_chk(2'd0, 4'd0);
    cnt_chk(2'd3, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed priority: lowest set index wins, every asserted line counts.
    log_ready = 1'b0;
    step(4'b0110, 1'b0, 1'b1, 2'd1, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    cnt_chk(2'd1, 4'd1);
    cnt_chk(2'd2, 4'd1);
    cnt_chk(2'd0, 4'd0);
    cnt_chk(2'd3, 4'd0);
    log_ready = 1'b1;
    step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Round-robin from pointer 0, wrap, and pointer retention across fixed mode.
    step(4'b1111, 1'b1, 1'b1, 2'd0, 1'b1);
    step(4'b1111, 1'b1, 1'b1, 2'd1, 1'b1);
    step(4'b1111, 1'b1, 1'b1, 2'd2, 1'b1);
    step(4'b1111, 1'b1, 1'b1, 2'd3, 1'b1);
    step(4'b1111, 1'b1, 1'b1, 2'd0, 1'b1);
    step(4'b0101, 1'b1, 1'b1, 2'd2, 1'b1);
    step(4'b0101, 1'b1, 1'b1, 2'd0, 1'b1);
    step(4'b1100, 1'b0, 1'b1, 2'd2, 1'b1);
    step(4'b0101, 1'b1, 1'b1, 2'd2, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    cnt_chk(2'd0, 4'd8);
    cnt_chk(2'd2, 4'd10);

    // Overflow: 10 events into a depth-8 log with no consumer.
    do_clr(4'b0000);
    log_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 1'b0, 1'b1, 2'd0, (i < 8) ? 1'b1 : 1'b0);
      if (i == 7) begin
        chk("full_no_ovf", 64'(log_ovf), 64'(0));
        chk("full_no_drop", 64'(drop_cnt), 64'(0));
      end
    end
    chk("ovf_set", 64'(log_ovf), 64'(1));
    chk("drop_cnt_2", 64'(drop_cnt), 64'(2));

    // Full log with simultaneous pop and push: both succeed.
    log_ready = 1'b1;
    step(4'b1000, 1'b0, 1'b1, 2'd3, 1'b1);
    chk("drop_cnt_hold", 64'(drop_cnt), 64'(2));
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("drained", 64'(log_valid), 64'(0));

    // Clear mid-stream: event in the clear cycle is ignored.
    log_ready = 1'b0;
    step(4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
    step(4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
    do_clr(4'b0001);
    chk("clr_log_valid", 64'(log_valid), 64'(0));
    chk("clr_log_ovf", 64'(log_ovf), 64'(0));
    chk("clr_drop_cnt", 64'(drop_cnt), 64'(0));
    cnt_chk(2'd0, 4'd0);
    cnt_chk(2'd1, 4'd0);
    cnt_chk(2'd2, 4'd0);
    cnt_chk(2'd3, 4'd0);
    chk("clr_log_empty", 64'(log_valid), 64'(0));

    // Saturation of a 4-bit counter.
    log_ready = 1'b1;
    for (int i = 0; i < 15; i++) step(4'b1000, 1'b0, 1'b1, 2'd3, 1'b1);
    cnt_chk(2'd3, 4'd15);
    for (int i = 0; i < 5; i++) step(4'b1000, 1'b0, 1'b1, 2'd3, 1'b1);
    cnt_chk(2'd3, 4'd15);
    cnt_chk(2'd0, 4'd0);

    // Asynchronous reset while draining.
    log_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
    log_ready = 1'b1;
    cnt_sel   = 2'd2;
    step(4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_win.delete();
    exp_log.delete();
    #1;
    chk("arst_win_valid", 64'(win_valid), 64'(0));
    chk("arst_win_idx", 64'(win_idx), 64'(0));
    chk("arst_log_valid", 64'(log_valid), 64'(0));
    chk("arst_log_idx", 64'(log_idx), 64'(0));
    chk("arst_log_ts", 64'(log_ts), 64'(0));
    chk("arst_log_ovf", 64'(log_ovf), 64'(0));
    chk("arst_drop_cnt", 64'(drop_cnt), 64'(0));
    chk("arst_cnt2", 64'(cnt_data), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("win_queue_empty", 64'(exp_win.size()), 64'(0));
    chk("log_queue_empty", 64'(exp_log.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
